// File: rtl/trace_pkg.sv
// Shared definitions for the multi-channel trace renderer: FSM encoding,
// trace palette and the ADC-to-row scaling helper.
package trace_pkg;

   typedef enum logic [1:0] {
      S_CLEAR = 2'd0,
      S_WAIT  = 2'd1,
      S_DRAW  = 2'd2,
      S_IDLE  = 2'd3
   } state_t;

   localparam logic [23:0] PAL_CH0   = 24'h00FF00;
   localparam logic [23:0] PAL_CH1   = 24'hFFFF00;
   localparam logic [23:0] PAL_CH2   = 24'h00FFFF;
   localparam logic [23:0] PAL_CH3   = 24'hFF00FF;
   localparam logic [23:0] PAL_BLACK = 24'h000000;

   // Colour of a trace plane; planes beyond the fourth reuse the palette.
   function automatic logic [23:0] palette(input logic [1:0] idx);
      logic [23:0] col_s;
      case (idx)
         2'd0:    col_s = PAL_CH0;
         2'd1:    col_s = PAL_CH1;
         2'd2:    col_s = PAL_CH2;
         2'd3:    col_s = PAL_CH3;
         default: col_s = PAL_BLACK;
      endcase
      return col_s;
   endfunction

   // Row of a sample: full-scale maps to row 0, zero maps to height-1.
   // The product is formed at full width so no precision is lost before the shift.
   function automatic logic [15:0] row_scale(input logic [15:0] adc,
                                             input logic [15:0] height,
                                             input int unsigned adc_width);
      logic [31:0] prod_s;
      logic [31:0] scaled_s;
      prod_s   = 32'(adc) * 32'(height);
      scaled_s = prod_s >> adc_width;
      return height - 16'd1 - scaled_s[15:0];
   endfunction

endpackage

// File: rtl/trace_pixel_out.sv
// Scan-out pixel path: picks the front buffer word, finds the lowest-index
// lit plane and registers its palette colour.
module trace_pixel_out #(
   parameter int NUM_CH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              front_sel,
   input  logic [NUM_CH-1:0] rd_data0,
   input  logic [NUM_CH-1:0] rd_data1,
   output logic [23:0]       pixel
);
   import trace_pkg::*;

   logic [NUM_CH-1:0] word_s;
   logic              found_s;
   logic [1:0]        idx_s;
   logic [23:0]       pixel_r;

   // Front-buffer select and priority encode, scanning down so the lowest set bit wins.
   always_comb begin
      word_s  = front_sel ? rd_data1 : rd_data0;
      found_s = 1'b0;
      idx_s   = 2'd0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         idx_s   = word_s[i] ? 2'(i) : idx_s;
         found_s = found_s | word_s[i];
      end
   end

   // Output colour register; black when no plane is lit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pixel_r <= 24'h000000;
      end else begin
         pixel_r <= found_s ? palette(idx_s) : PAL_BLACK;
      end
   end

   assign pixel = pixel_r;

endmodule

// File: rtl/trace_renderer.sv
// Multi-channel oscilloscope trace renderer: clears and draws the back
// bit-plane buffer while the front one is scanned out, swapping on vsync.
module trace_renderer #(
   parameter int NUM_CH     = 2,
   parameter int ADC_WIDTH  = 12,
   parameter int COL_WIDTH  = 10,
   parameter int ROW_WIDTH  = 9,
   parameter int ADDR_WIDTH = 19
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        vsync,
   input  logic                        mode_connect,
   input  logic [COL_WIDTH-1:0]        width,
   input  logic [ROW_WIDTH-1:0]        height,
   input  logic                        s_valid,
   output logic                        s_ready,
   input  logic [NUM_CH*ADC_WIDTH-1:0] s_data,
   input  logic [ADDR_WIDTH-1:0]       rd_addr,
   input  logic [NUM_CH-1:0]           rd_data0,
   input  logic [NUM_CH-1:0]           rd_data1,
   output logic [ADDR_WIDTH-1:0]       addr0,
   output logic [ADDR_WIDTH-1:0]       addr1,
   output logic [NUM_CH-1:0]           we0,
   output logic [NUM_CH-1:0]           we1,
   output logic [NUM_CH-1:0]           wd,
   output logic [23:0]                 pixel,
   output logic                        front_sel,
   output logic                        busy,
   output logic                        overrun
);
   import trace_pkg::*;

   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   state_t                  state_r;
   logic                    front_sel_r, busy_r, overrun_r, s_ready_r;
   logic                    vsync_d_r, clr_first_r, mode_r, prev_valid_r;
   logic [ADDR_WIDTH-1:0]   clr_cnt_r, render_addr_r;
   logic [COL_WIDTH-1:0]    width_r, col_r;
   logic [ROW_WIDTH-1:0]    height_r, cur_row_r, end_row_r;
   logic [CH_W-1:0]         ch_r;
   logic [NUM_CH-1:0]       we0_r, we1_r, wd_r;
   logic [ROW_WIDTH-1:0]    rows_r [NUM_CH];
   logic [ROW_WIDTH-1:0]    prev_r [NUM_CH];

   logic                    vsync_rise_s, clr_last_s, sel_conn_s;
   logic [ADDR_WIDTH-1:0]   clr_w_s, clr_h_s, draw_addr_s;
   logic [ROW_WIDTH-1:0]    new_rows_s [NUM_CH];
   logic [ROW_WIDTH-1:0]    sel_row_s, sel_prev_s, lo_s, hi_s;
   logic [CH_W-1:0]         nxt_ch_s;
   logic [NUM_CH-1:0]       onehot_s;

   // Scaled row of every channel in the incoming sample word.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         new_rows_s[c] = ROW_WIDTH'(row_scale(16'(s_data[c*ADC_WIDTH +: ADC_WIDTH]),
                                              16'(height_r), ADC_WIDTH));
      end
   end

   // Clear-end detect (uses the ports on the first clear cycle, before they are latched) and draw address.
   always_comb begin
      vsync_rise_s = vsync & ~vsync_d_r;
      clr_w_s      = clr_first_r ? ADDR_WIDTH'(width)  : ADDR_WIDTH'(width_r);
      clr_h_s      = clr_first_r ? ADDR_WIDTH'(height) : ADDR_WIDTH'(height_r);
      clr_last_s   = (clr_cnt_r == clr_w_s * clr_h_s - ADDR_WIDTH'(1));
      draw_addr_s  = ADDR_WIDTH'(cur_row_r) * ADDR_WIDTH'(width_r) + ADDR_WIDTH'(col_r);
      onehot_s     = NUM_CH'(1) << ch_r;
   end

   // Row span of the next channel to draw: a single dot, or prev..row when connecting.
   always_comb begin
      if (state_r == S_WAIT) begin
         nxt_ch_s   = '0;
         sel_row_s  = new_rows_s[0];
         sel_prev_s = prev_r[0];
         sel_conn_s = mode_connect;
      end else begin
         if (ch_r < CH_W'(NUM_CH - 1)) begin
            nxt_ch_s = ch_r + CH_W'(1);
         end else begin
            nxt_ch_s = '0;
         end
         sel_row_s  = rows_r[nxt_ch_s];
         sel_prev_s = prev_r[nxt_ch_s];
         sel_conn_s = mode_r;
      end
      if (sel_conn_s && prev_valid_r) begin
         if (sel_prev_s < sel_row_s) begin
            lo_s = sel_prev_s;
            hi_s = sel_row_s;
         end else begin
            lo_s = sel_row_s;
            hi_s = sel_prev_s;
         end
      end else begin
         lo_s = sel_row_s;
         hi_s = sel_row_s;
      end
   end

   // Render FSM with registered write port, handshake, busy and overrun outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= S_CLEAR;
         front_sel_r   <= 1'b0;
         busy_r        <= 1'b1;
         overrun_r     <= 1'b0;
         s_ready_r     <= 1'b0;
         vsync_d_r     <= 1'b0;
         clr_first_r   <= 1'b1;
         mode_r        <= 1'b0;
         prev_valid_r  <= 1'b0;
         clr_cnt_r     <= '0;
         render_addr_r <= '0;
         width_r       <= '0;
         height_r      <= '0;
         col_r         <= '0;
         cur_row_r     <= '0;
         end_row_r     <= '0;
         ch_r          <= '0;
         we0_r         <= '0;
         we1_r         <= '0;
         wd_r          <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            rows_r[c] <= '0;
            prev_r[c] <= '0;
         end
      end else begin
         vsync_d_r <= vsync;
         overrun_r <= vsync_rise_s && (state_r != S_IDLE);
         we0_r     <= '0;
         we1_r     <= '0;
         wd_r      <= '0;
         case (state_r)
            S_CLEAR: begin
               if (clr_first_r) begin
                  width_r  <= width;
                  height_r <= height;
               end
               clr_first_r   <= 1'b0;
               render_addr_r <= clr_cnt_r;
               if (front_sel_r) begin
                  we0_r <= '1;
               end else begin
                  we1_r <= '1;
               end
               if (clr_last_s) begin
                  clr_cnt_r <= '0;
                  col_r     <= '0;
                  s_ready_r <= 1'b1;
                  state_r   <= S_WAIT;
               end else begin
                  clr_cnt_r <= clr_cnt_r + ADDR_WIDTH'(1);
               end
            end
            S_WAIT: begin
               if (s_valid && s_ready_r) begin
                  s_ready_r <= 1'b0;
                  mode_r    <= mode_connect;
                  for (int c = 0; c < NUM_CH; c++) begin
                     rows_r[c] <= new_rows_s[c];
                  end
                  ch_r      <= '0;
                  cur_row_r <= lo_s;
                  end_row_r <= hi_s;
                  state_r   <= S_DRAW;
               end
            end
            S_DRAW: begin
               render_addr_r <= draw_addr_s;
               wd_r          <= onehot_s;
               if (front_sel_r) begin
                  we0_r <= onehot_s;
               end else begin
                  we1_r <= onehot_s;
               end
               if (cur_row_r != end_row_r) begin
                  cur_row_r <= cur_row_r + ROW_WIDTH'(1);
               end else if (ch_r != CH_W'(NUM_CH - 1)) begin
                  ch_r      <= nxt_ch_s;
                  cur_row_r <= lo_s;
                  end_row_r <= hi_s;
               end else begin
                  for (int c = 0; c < NUM_CH; c++) begin
                     prev_r[c] <= rows_r[c];
                  end
                  prev_valid_r <= 1'b1;
                  if (col_r == width_r - COL_WIDTH'(1)) begin
                     busy_r  <= 1'b0;
                     state_r <= S_IDLE;
                  end else begin
                     col_r     <= col_r + COL_WIDTH'(1);
                     s_ready_r <= 1'b1;
                     state_r   <= S_WAIT;
                  end
               end
            end
            S_IDLE: begin
               if (vsync_rise_s) begin
                  front_sel_r  <= ~front_sel_r;
                  prev_valid_r <= 1'b0;
                  clr_first_r  <= 1'b1;
                  busy_r       <= 1'b1;
                  state_r      <= S_CLEAR;
               end
            end
            default: begin
               state_r <= S_CLEAR;
            end
         endcase
      end
   end

   assign addr0     = front_sel_r ? render_addr_r : rd_addr;
   assign addr1     = front_sel_r ? rd_addr : render_addr_r;
   assign we0       = we0_r;
   assign we1       = we1_r;
   assign wd        = wd_r;
   assign s_ready   = s_ready_r;
   assign front_sel = front_sel_r;
   assign busy      = busy_r;
   assign overrun   = overrun_r;

   trace_pixel_out #(.NUM_CH(NUM_CH)) u_pixel_out (
      .clk       (clk),
      .rst       (rst),
      .front_sel (front_sel_r),
      .rd_data0  (rd_data0),
      .rd_data1  (rd_data1),
      .pixel     (pixel)
   );

endmodule

// File: tb/tb_trace_renderer.sv
// Directed bench for trace_renderer: 4x4 frame, two channels.
module tb_trace_renderer;

   logic        clk = 1'b0;
   logic        rst, vsync, mode_connect, s_valid;
   logic [9:0]  width;
   logic [8:0]  height;
   logic [23:0] s_data;
   logic [18:0] rd_addr;
   logic [1:0]  rd_data0, rd_data1;
   logic        s_ready, front_sel, busy, overrun;
   logic [18:0] addr0, addr1;
   logic [1:0]  we0, we1, wd;
   logic [23:0] pixel;

   trace_renderer dut (
      .clk(clk), .rst(rst), .vsync(vsync), .mode_connect(mode_connect),
      .width(width), .height(height), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .rd_addr(rd_addr), .rd_data0(rd_data0), .rd_data1(rd_data1),
      .addr0(addr0), .addr1(addr1), .we0(we0), .we1(we1), .wd(wd),
      .pixel(pixel), .front_sel(front_sel), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        b;
      logic [18:0] addr;
      logic [1:0]  we;
      logic [1:0]  wd;
      int          cyc;
   } wr_t;

   typedef struct {
      logic [1:0]  rd0;
      logic [1:0]  rd1;
      logic [23:0] exp_pix;
   } pix_vec_t;

   wr_t      log_q[$];
   wr_t      exp_q[$];
   pix_vec_t pv[7];
   int       n_cmp = 0;
   int       n_bad = 0;
   int       cyc = 0;
   int       ovr_cnt = 0;
   int       log_base = 0;
   int       ovr_base;

   always @(posedge clk) cyc <= cyc + 1;

   // Write and overrun monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (we0 != 2'b00) log_q.push_back('{1'b0, addr0, we0, wd, cyc});
         if (we1 != 2'b00) log_q.push_back('{1'b1, addr1, we1, wd, cyc});
         if (overrun) ovr_cnt <= ovr_cnt + 1;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
      end
   endtask

   task automatic ex(input logic b, input int addr, input logic [1:0] we, input logic [1:0] wdv);
      exp_q.push_back('{b, 19'(addr), we, wdv, 0});
   endtask

   task automatic check_log(input string name);
      int n;
      n = log_q.size() - log_base;
      chk({name, " count"}, 64'(n), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < n; i++) begin
         chk($sformatf("%s[%0d]", name, i),
             {log_q[log_base+i].b, log_q[log_base+i].addr, log_q[log_base+i].we, log_q[log_base+i].wd},
             {exp_q[i].b, exp_q[i].addr, exp_q[i].we, exp_q[i].wd});
      end
      exp_q.delete();
      log_base = log_q.size();
   endtask

   task automatic wait_ready(input int max);
      int k = 0;
      while (!s_ready && k < max) begin
         tick();
         k++;
      end
      chk("wait_ready", 64'(s_ready), 64'(1));
   endtask

   task automatic wait_idle(input int max);
      int k = 0;
      while (busy && k < max) begin
         tick();
         k++;
      end
      chk("wait_idle", 64'(busy), 64'(0));
      tick();
      tick();
   endtask

   task automatic send(input logic [11:0] c0, input logic [11:0] c1);
      wait_ready(100);
      s_data  = {c1, c0};
      s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
   endtask

   task automatic apply_pix(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         rd_data0 = pv[i].rd0;
         rd_data1 = pv[i].rd1;
         tick();
         chk($sformatf("pixel[%0d]", i), 64'(pixel), 64'(pv[i].exp_pix));
      end
   endtask

   initial begin
      pv[0] = '{2'b00, 2'b11, 24'h00FF00};
      pv[1] = '{2'b00, 2'b10, 24'hFFFF00};
      pv[2] = '{2'b11, 2'b00, 24'h000000};
      pv[3] = '{2'b10, 2'b01, 24'h00FF00};
      pv[4] = '{2'b10, 2'b11, 24'hFFFF00};
      pv[5] = '{2'b00, 2'b01, 24'h000000};
      pv[6] = '{2'b11, 2'b00, 24'h00FF00};

      rst = 1'b1; vsync = 1'b0; mode_connect = 1'b0; s_valid = 1'b0;
      width = 10'd4; height = 9'd4; s_data = 24'd0; rd_addr = 19'd0;
      rd_data0 = 2'b00; rd_data1 = 2'b00;
      repeat (3) tick();
      chk("rst front_sel", 64'(front_sel), 64'(0));
      chk("rst we0", 64'(we0), 64'(0));
      chk("rst we1", 64'(we1), 64'(0));
      chk("rst wd", 64'(wd), 64'(0));
      chk("rst pixel", 64'(pixel), 64'(0));
      chk("rst overrun", 64'(overrun), 64'(0));
      chk("rst s_ready", 64'(s_ready), 64'(0));
      rst = 1'b0;

      // Initial clear of buffer 1.
      wait_ready(100);
      for (int i = 0; i < 16; i++) ex(1'b1, i, 2'b11, 2'b00);
      check_log("clear1");

      // Dot mode: ch0 at bottom row, ch1 at top row.
      for (int c = 0; c < 4; c++) send(12'd0, 12'd4095);
      wait_idle(100);
      for (int c = 0; c < 4; c++) begin
         ex(1'b1, 12 + c, 2'b01, 2'b01);
         ex(1'b1, c, 2'b10, 2'b10);
      end
      check_log("dot");

      // Swap on vsync in idle, then clear of buffer 0.
      ovr_base = ovr_cnt;
      vsync = 1'b1; tick(); tick(); vsync = 1'b0;
      wait_ready(100);
      chk("swap1 front_sel", 64'(front_sel), 64'(1));
      chk("swap1 no overrun", 64'(ovr_cnt - ovr_base), 64'(0));
      for (int i = 0; i < 16; i++) ex(1'b0, i, 2'b11, 2'b00);
      check_log("clear0");

      // Stalled source: s_ready held, no writes.
      for (int i = 0; i < 10; i++) begin
         tick();
         chk($sformatf("stall s_ready[%0d]", i), 64'(s_ready), 64'(1));
      end
      chk("stall writes", 64'(log_q.size() - log_base), 64'(0));

      // Connect mode with an overrun vsync mid-frame.
      mode_connect = 1'b1;
      send(12'd0, 12'd0);
      send(12'd4095, 12'd0);
      ovr_base = ovr_cnt;
      vsync = 1'b1; tick(); vsync = 1'b0;
      repeat (4) tick();
      chk("overrun pulses", 64'(ovr_cnt - ovr_base), 64'(1));
      chk("overrun no swap", 64'(front_sel), 64'(1));
      send(12'd4095, 12'd0);
      send(12'd4095, 12'd0);
      wait_idle(100);
      if (log_q.size() - log_base >= 6) begin
         for (int i = 2; i < 5; i++) begin
            chk($sformatf("segment adjacency[%0d]", i),
                64'(log_q[log_base+i+1].cyc - log_q[log_base+i].cyc), 64'(1));
         end
      end else begin
         chk("segment length", 64'(log_q.size() - log_base), 64'(6));
      end
      ex(1'b0, 12, 2'b01, 2'b01); ex(1'b0, 12, 2'b10, 2'b10);
      ex(1'b0, 1, 2'b01, 2'b01);  ex(1'b0, 5, 2'b01, 2'b01);
      ex(1'b0, 9, 2'b01, 2'b01);  ex(1'b0, 13, 2'b01, 2'b01);
      ex(1'b0, 13, 2'b10, 2'b10);
      ex(1'b0, 2, 2'b01, 2'b01);  ex(1'b0, 14, 2'b10, 2'b10);
      ex(1'b0, 3, 2'b01, 2'b01);  ex(1'b0, 15, 2'b10, 2'b10);
      check_log("connect");
      chk("connect front_sel", 64'(front_sel), 64'(1));

      // Scan-out from buffer 1.
      rd_addr = 19'h12345;
      tick();
      chk("front addr1", 64'(addr1), 64'(19'h12345));
      chk("front we1", 64'(we1), 64'(0));
      apply_pix(0, 3);

      // Second swap, scan-out from buffer 0.
      vsync = 1'b1; tick(); tick(); vsync = 1'b0;
      chk("swap2 front_sel", 64'(front_sel), 64'(0));
      chk("front addr0", 64'(addr0), 64'(19'h12345));
      apply_pix(4, 6);

      // Asynchronous reset in the middle of a clear.
      chk("pre-reset we1", 64'(we1), 64'(2'b11));
      rst = 1'b1;
      #1;
      chk("async rst we1", 64'(we1), 64'(0));
      chk("async rst pixel", 64'(pixel), 64'(0));
      chk("async rst s_ready", 64'(s_ready), 64'(0));
      chk("async rst wd", 64'(wd), 64'(0));
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/trace_renderer.md
Name: trace_renderer

Overview:
- Parametrised successor of the single-channel oscilloscope video controller.
- Renders NUM_CH ADC traces into a ping-pong pair of bit-plane framebuffers: one buffer is cleared and drawn (back) while the other is scanned out (front).
- Adds a sample handshake, a connected-line (vertical fill) mode, per-channel bit-plane writes, and a safe buffer swap on vsync with overrun detection.
- Sits between the ADC sample FIFO and the HDMI pixel pipeline.

Parameters:
- NUM_CH, 2, number of traces; framebuffer word is NUM_CH bits, one bit-plane per channel.
- ADC_WIDTH, 12, bits per channel sample.
- COL_WIDTH, 10, width of the column counter and of the width port.
- ROW_WIDTH, 9, width of the row counter and of the height port.
- ADDR_WIDTH, 19, framebuffer address width.

Ports:
- clk  in  1  system clock, single domain
- rst  in  1  asynchronous, active-high reset
- vsync  in  1  frame sync, synchronous to clk; rising edge detected internally
- mode_connect  in  1  0 = dot per sample, 1 = vertical segment from previous row
- width  in  COL_WIDTH  active columns, latched on entry to S_CLEAR
- height  in  ROW_WIDTH  active rows, latched on entry to S_CLEAR
- s_valid  in  1  sample word valid
- s_ready  out  1  renderer accepts sample word
- s_data  in  NUM_CH*ADC_WIDTH  channel c occupies bits [c*ADC_WIDTH +: ADC_WIDTH]
- rd_addr  in  ADDR_WIDTH  scan-out read address
- rd_data0  in  NUM_CH  buffer 0 read data
- rd_data1  in  NUM_CH  buffer 1 read data
- addr0  out  ADDR_WIDTH  buffer 0 address: rd_addr when front, render address when back
- addr1  out  ADDR_WIDTH  buffer 1 address, same rule
- we0  out  NUM_CH  buffer 0 per-plane write enable
- we1  out  NUM_CH  buffer 1 per-plane write enable
- wd  out  NUM_CH  write data, shared by both buffers
- pixel  out  24  {R,G,B}, registered
- front_sel  out  1  index of the displayed buffer
- busy  out  1  high in S_CLEAR, S_WAIT, S_DRAW
- overrun  out  1  one-cycle pulse when vsync arrives while busy

Behaviour:
- Reset values: state S_CLEAR, front_sel 0, counters 0, we0/we1 0, wd 0, pixel 0, overrun 0, s_ready 0, prev_row invalid.
- S_CLEAR:
  - addr = clr_cnt; we_back = all ones; wd = 0.
  - clr_cnt counts 0 .. width*height-1, one per cycle, so the clear takes width*height cycles.
  - Next state S_WAIT, with col = 0.
- S_WAIT:
  - s_ready = 1; a sample is captured on s_valid && s_ready.
  - Per channel: row_c = height-1 - ((adc_c * height) >> ADC_WIDTH), computed at full product width; the result is always < height.
  - Next state S_DRAW, with ch = 0.
- S_DRAW:
  - One pixel per cycle for channel ch: addr = row*width + col; we_back = one-hot(ch); wd = one-hot(ch).
  - Dot mode, or first column (prev invalid): write a single pixel at row_c.
  - Connect mode: write rows min(prev_c,row_c) .. max(prev_c,row_c) inclusive, ascending.
  - After channel ch is finished: ch+1; after the last channel, store prev_c = row_c and set prev valid.
  - Then col+1 and return to S_WAIT, or go to S_IDLE when col == width-1.
- S_IDLE:
  - busy = 0, no writes.
  - On the vsync rising edge: toggle front_sel, clear prev valid, go to S_CLEAR (which clears the new back buffer).
- vsync edge while busy: overrun pulses one cycle; no swap; rendering continues. The swap waits for the first vsync edge seen in S_IDLE.
- mode_connect is sampled at S_WAIT capture; a change takes effect from the next column.
- Address mux: the front buffer gets rd_addr and we = 0; the back buffer gets the render address.
- Pixel path, registered one cycle after rd_data:
  - Select rd_data0 or rd_data1 by front_sel.
  - The lowest-index set bit selects a colour from the palette; no bit set gives black.
- Asynchronous reset mid-operation forces all outputs to their reset values immediately. No partial frame is swapped.

Decomposition:
- Package trace_pkg holds:
  - state encoding S_CLEAR/S_WAIT/S_DRAW/S_IDLE;
  - palette constants: ch0 00FF00, ch1 FFFF00, ch2 00FFFF, ch3 FF00FF;
  - the row-scaling function.
- Sub-module trace_pixel_out: front-buffer mux, priority encoder, palette lookup, output register.

Test Plan:
- Reset, width=4, height=4 -> front_sel=0; 16 cycles of we1=2'b11, wd=0, addr1=0..15; we0=0 throughout.
- Dot mode, every sample ch0=0 and ch1=4095 -> ch0 writes addr 12,13,14,15 (we1=01); ch1 writes addr 0,1,2,3 (we1=10); busy falls; vsync -> front_sel=1 and buffer 0 is cleared.
- Connect mode, ch0 col0=0, col1=4095 -> col1 writes addr 1,5,9,13 in 4 consecutive cycles, we=01.
- vsync pulse mid-draw -> overrun high exactly 1 cycle, front_sel unchanged; the next vsync in S_IDLE toggles it.
- s_valid held low 10 cycles in S_WAIT -> no writes, s_ready stays high; s_valid asserted -> capture and draw.
- Scan-out: front rd_data=2'b11 -> pixel=00FF00 one cycle later; 2'b10 -> FFFF00; 2'b00 -> 000000.
